square_painter: RTL and testbench
=================================

// Module: square_painter
// PURPOSE
//  Consumer of the square location (x_loc, y_loc) chosen for the game square on the 640x480 VGA screen.
//  On start it erases the previously drawn square (colour 0), then draws the new one (colour 1).
//  It emits one pixel write per cycle to the frame-buffer writer, using a valid/ready handshake.
//  Pixels that fall off-screen are clipped (no write is issued for them).
// PARAMETERS
//  SIZE      16   square edge length in pixels (>=1)
//  SCREEN_W  640  visible width; pixels with x >= SCREEN_W are clipped
//  SCREEN_H  480  visible height; pixels with y >= SCREEN_H are clipped
// PORTS
//  clk        in   1   system clock
//  reset      in   1   synchronous, active-high reset
//  start      in   1   request a redraw; sampled only in IDLE
//  x_loc      in   11  new square top-left x; latched on accepted start
//  y_loc      in   11  new square top-left y; latched on accepted start
//  pix_ready  in   1   frame buffer accepts a write this cycle
//  px_x       out  11  pixel x address
//  px_y       out  11  pixel y address
//  px_color   out  1   0 = erase (background), 1 = square
//  px_we      out  1   pixel write valid
//  busy       out  1   high in ERASE and DRAW
//  done       out  1   one-cycle pulse when the redraw completes
// BEHAVIOUR
//  Reset:
//   - All outputs are 0; state is IDLE.
//   - prev_valid = 0; prev_x = prev_y = 0; col = row = 0.
//  States:
//   - IDLE  -> ERASE when start && prev_valid.
//   - IDLE  -> DRAW  when start && !prev_valid.
//   - ERASE -> DRAW  after the last pixel of the erase pass.
//   - DRAW  -> DONE  after the last pixel of the draw pass.
//   - DONE  -> IDLE  unconditionally; done = 1 for exactly this one cycle.
//   - On entering DONE: prev_x/prev_y <= the latched new location; prev_valid <= 1.
//  Scan order and timing:
//   - Each pass scans row-major: col 0..SIZE-1 inner, row 0..SIZE-1 outer. Counters are cleared at the start of each pass.
//   - All outputs are registered. The first pixel appears the cycle after start is sampled.
//   - Pixel address: px_x = base_x + col, px_y = base_y + row. Sums are computed 12 bits wide, so no 11-bit wrap.
//   - Base is prev_* in ERASE and new_* in DRAW. px_color = 0 in ERASE, 1 in DRAW.
//  Clipping:
//   - If sum_x >= SCREEN_W or sum_y >= SCREEN_H, the pixel is clipped.
//   - A clipped pixel holds px_we = 0 for one cycle, then the scan advances. pix_ready is ignored for clipped pixels.
//  Handshake:
//   - An on-screen pixel holds px_we = 1 with px_x/px_y/px_color stable until the cycle with pix_ready = 1.
//   - The scan advances on the edge after that cycle.
//  Latency:
//   - With pix_ready tied high, a pass takes SIZE*SIZE cycles.
//   - done asserts at start+1+SIZE^2 with no prior square, or start+1+2*SIZE^2 with one.
//  Boundary conditions:
//   - start outside IDLE is ignored; x_loc/y_loc changes while busy are ignored.
//   - start asserted in DONE is ignored.
//   - reset mid-pass: next cycle is IDLE with all outputs 0 and prev_valid = 0. A partially drawn square is not erased.
//   - Outside ERASE/DRAW: px_we = 0 and px_x = px_y = 0.
// STRUCTURE
//  Package square_pkg:
//   - typedef enum logic [2:0] {IDLE, ERASE, DRAW, DONE} paint_state_t.
//   - localparams SCREEN_W, SCREEN_H, COLOR_BG = 1'b0, COLOR_SQ = 1'b1.
//  Sub-module pixel_scan_counter (parameter SIZE):
//   - inputs clk, reset, clear, advance; outputs col, row, last.
//   - Row-major wrap; last = (col == SIZE-1 && row == SIZE-1).
//  Top level: FSM, location latches, 12-bit adders with clip compare, output registers.
// TESTING (bench overrides SIZE = 4, pix_ready = 1 unless noted)
//  1. Reset, then start with (10,20):
//     - no erase pass; 16 writes, colour 1, (10,20),(11,20)..(13,23) in row-major order.
//     - busy high for 16 cycles; done pulses at start+17.
//  2. Next start with (100,200):
//     - 16 colour-0 writes over x 10..13, y 20..23.
//     - then 16 colour-1 writes over x 100..103, y 200..203; done at start+33.
//  3. Start with (638,478):
//     - only 4 writes, at (638,478),(639,478),(638,479),(639,479).
//     - the pass still takes 16 cycles; no address exceeds 639/479.
//  4. pix_ready low for 3 cycles while pixel 5 is presented:
//     - px_we/px_x/px_y/px_color held stable; total pass length 19 cycles.
//  5. start pulsed mid-DRAW: ignored, no second redraw.
//     reset at the 8th DRAW pixel: all outputs 0 next cycle; the following start (5,5) skips erase (16 writes only).

Source files
------------

// File: rtl/square_painter_pkg.sv
// Shared types and constants for the square painter.
// Holds the FSM state encoding, coordinate widths, screen limits and colour codes.
package square_pkg;

    localparam int unsigned COORD_W  = 11;
    localparam int unsigned SUM_W    = 12;
    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    localparam logic COLOR_BG = 1'b0;
    localparam logic COLOR_SQ = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        DRAW,
        DONE
    } paint_state_t;

endpackage

// File: rtl/square_painter_if.sv
// Pixel write bus from the painter to the frame-buffer writer.
//   px_x, px_y : pixel address
//   px_color   : 0 = background, 1 = square
//   px_we      : write valid
//   pix_ready  : frame buffer accepts the write this cycle
interface square_painter_if;
    import square_pkg::*;

    logic [COORD_W-1:0] px_x;
    logic [COORD_W-1:0] px_y;
    logic               px_color;
    logic               px_we;
    logic               pix_ready;

    modport master (
        input  pix_ready,
        output px_x,
        output px_y,
        output px_color,
        output px_we
    );

    modport slave (
        output pix_ready,
        input  px_x,
        input  px_y,
        input  px_color,
        input  px_we
    );

endinterface

// File: rtl/square_painter_pixel_scan_counter.sv
// Row-major col/row scan counter over a SIZE x SIZE square.
//   clk, reset : clock, synchronous active-high reset
//   clear      : restart the scan at (0,0)
//   advance    : step to the next pixel (col inner, row outer, wraps)
//   col, row   : scan position being loaded on this edge, so the caller can
//                register an address for it in the same cycle
//   last       : the current (registered) position is the final pixel
module pixel_scan_counter #(
    parameter  int unsigned SIZE = 16,
    localparam int unsigned CW   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          advance,
    output logic [CW-1:0] col,
    output logic [CW-1:0] row,
    output logic          last
);

    localparam logic [CW-1:0] MAX_IDX = CW'(SIZE - 1);

    logic [CW-1:0] col_q;
    logic [CW-1:0] row_q;

    // Next scan position
    always_comb begin
        col = col_q;
        row = row_q;
        if (clear) begin
            col = '0;
            row = '0;
        end else if (advance) begin
            if (col_q == MAX_IDX) begin
                col = '0;
                row = (row_q == MAX_IDX) ? '0 : row_q + CW'(1);
            end else begin
                col = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col;
            row_q <= row;
        end
    end

    assign last = (col_q == MAX_IDX) && (row_q == MAX_IDX);

endmodule

// File: rtl/square_painter.sv
// Erases the previously drawn square, then draws the square at the newly
// requested location, issuing one clipped pixel write per cycle.
//   clk, reset   : clock, synchronous active-high reset
//   start        : redraw request, honoured only in IDLE
//   x_loc, y_loc : new top-left corner, latched on an accepted start
//   pix          : pixel write bus (master side)
//   busy         : high while erasing or drawing
//   done         : one-cycle pulse when the redraw finishes
module square_painter
    import square_pkg::*;
#(
    parameter int unsigned SIZE     = 16,
    parameter int unsigned SCREEN_W = square_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H = square_pkg::SCREEN_H
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [COORD_W-1:0]  x_loc,
    input  logic [COORD_W-1:0]  y_loc,
    square_painter_if.master    pix,
    output logic                busy,
    output logic                done
);

    localparam int unsigned CW = (SIZE > 1) ? $clog2(SIZE) : 1;

    paint_state_t state;
    paint_state_t state_nxt;

    logic [COORD_W-1:0] new_x, new_y;
    logic [COORD_W-1:0] prev_x, prev_y;
    logic               prev_valid;

    logic [CW-1:0] col, row;
    logic          last;
    logic          clear;
    logic          advance;
    logic          in_pass;
    logic          accept_start;

    logic [COORD_W-1:0] base_x, base_y;
    logic [SUM_W-1:0]   sum_x, sum_y;
    logic               clip;

    logic               px_we_q, px_color_q;
    logic [COORD_W-1:0] px_x_q, px_y_q;
    logic               px_we_d, px_color_d, busy_d, done_d;
    logic [COORD_W-1:0] px_x_d, px_y_d;

    assign in_pass      = (state == ERASE) || (state == DRAW);
    assign accept_start = (state == IDLE) && start;
    // A clipped pixel (px_we low) moves on after one cycle; a real write waits for ready.
    assign advance      = in_pass && (!px_we_q || pix.pix_ready);

    pixel_scan_counter #(.SIZE(SIZE)) u_scan (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .advance (advance),
        .col     (col),
        .row     (row),
        .last    (last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear     = 1'b1;
                    state_nxt = prev_valid ? ERASE : DRAW;
                end
            end
            ERASE: begin
                if (advance && last) begin
                    clear     = 1'b1;
                    state_nxt = DRAW;
                end
            end
            DRAW: begin
                if (advance && last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: values for the pixel presented in the next cycle
    always_comb begin
        px_we_d    = 1'b0;
        px_color_d = COLOR_BG;
        px_x_d     = '0;
        px_y_d     = '0;
        busy_d     = 1'b0;
        done_d     = (state_nxt == DONE);

        // The new location is not yet latched on the start edge, so take it from the inputs.
        if (state_nxt == ERASE) begin
            base_x = prev_x;
            base_y = prev_y;
        end else if (accept_start) begin
            base_x = x_loc;
            base_y = y_loc;
        end else begin
            base_x = new_x;
            base_y = new_y;
        end

        sum_x = SUM_W'(base_x) + SUM_W'(col);
        sum_y = SUM_W'(base_y) + SUM_W'(row);
        clip  = (sum_x >= SUM_W'(SCREEN_W)) || (sum_y >= SUM_W'(SCREEN_H));

        if ((state_nxt == ERASE) || (state_nxt == DRAW)) begin
            busy_d     = 1'b1;
            px_color_d = (state_nxt == DRAW) ? COLOR_SQ : COLOR_BG;
            if (!clip) begin
                px_we_d = 1'b1;
                px_x_d  = sum_x[COORD_W-1:0];
                px_y_d  = sum_y[COORD_W-1:0];
            end
        end
    end

    // Location latches and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            new_x      <= '0;
            new_y      <= '0;
            prev_x     <= '0;
            prev_y     <= '0;
            prev_valid <= 1'b0;
            px_we_q    <= 1'b0;
            px_color_q <= 1'b0;
            px_x_q     <= '0;
            px_y_q     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (accept_start) begin
                new_x <= x_loc;
                new_y <= y_loc;
            end
            if ((state == DRAW) && (state_nxt == DONE)) begin
                prev_x     <= new_x;
                prev_y     <= new_y;
                prev_valid <= 1'b1;
            end
            px_we_q    <= px_we_d;
            px_color_q <= px_color_d;
            px_x_q     <= px_x_d;
            px_y_q     <= px_y_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

    assign pix.px_we    = px_we_q;
    assign pix.px_color = px_color_q;
    assign pix.px_x     = px_x_q;
    assign pix.px_y     = px_y_q;

endmodule

// File: tb/tb_square_painter.sv
// Directed bench for square_painter with SIZE = 4.
module tb_square_painter;

    localparam int unsigned SIZE = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] x_loc;
    logic [10:0] y_loc;
    logic        busy;
    logic        done;

    square_painter_if pix ();

    square_painter #(.SIZE(SIZE)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .x_loc (x_loc),
        .y_loc (y_loc),
        .pix   (pix),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int wr_q[$];
    int exp_q[$];
    int snap_q[$];
    int done_cyc;
    int busy_cyc;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, expv, expv);
        end
    endtask

    function automatic int pk(input int x, input int y, input int c);
        return (c << 22) | (y << 11) | x;
    endfunction

    // Expected writes of one pass: row-major, off-screen pixels dropped.
    task automatic add_exp(input int bx, input int by, input int c);
        for (int r = 0; r < int'(SIZE); r++) begin
            for (int cc = 0; cc < int'(SIZE); cc++) begin
                if ((bx + cc) < 640 && (by + r) < 480) exp_q.push_back(pk(bx + cc, by + r, c));
            end
        end
    endtask

    task automatic check_writes(input string tag);
        int n;
        chk({tag, "_count"}, wr_q.size(), exp_q.size());
        n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk(tag, wr_q[i], exp_q[i]);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_we"},    int'(pix.px_we),    0);
        chk({tag, "_x"},     int'(pix.px_x),     0);
        chk({tag, "_y"},     int'(pix.px_y),     0);
        chk({tag, "_color"}, int'(pix.px_color), 0);
        chk({tag, "_busy"},  int'(busy),         0);
        chk({tag, "_done"},  int'(done),         0);
    endtask

    // Issues a start and follows the redraw until done (cycle 1 = start+1).
    task automatic run_redraw(input int x, input int y, input int stall_at, input int stall_len,
                              input int mid_start_at, input int rst_at);
        wr_q.delete();
        snap_q.delete();
        done_cyc = -1;
        busy_cyc = 0;
        x_loc = 11'(x);
        y_loc = 11'(y);
        start = 1'b1;
        step();
        start = 1'b0;
        x_loc = 11'h7ff;
        y_loc = 11'h7ff;
        for (int n = 1; n <= 200; n++) begin
            pix.pix_ready = (n >= stall_at && n < stall_at + stall_len) ? 1'b0 : 1'b1;
            start = (n == mid_start_at);
            if (n == rst_at) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                break;
            end
            if (!pix.pix_ready)
                snap_q.push_back((int'(pix.px_we) << 23) |
                                 pk(int'(pix.px_x), int'(pix.px_y), int'(pix.px_color)));
            if (pix.px_we && pix.pix_ready)
                wr_q.push_back(pk(int'(pix.px_x), int'(pix.px_y), int'(pix.px_color)));
            if (busy) busy_cyc++;
            if (done) begin
                done_cyc = n;
                break;
            end
            step();
        end
        start = 1'b0;
        pix.pix_ready = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        x_loc = '0;
        y_loc = '0;
        pix.pix_ready = 1'b1;
        repeat (3) step();
        check_idle_outputs("rst_hold");
        reset = 1'b0;
        step();
        check_idle_outputs("rst_rel");

        // 1: first square, no erase pass
        run_redraw(10, 20, 0, 0, 0, 0);
        exp_q.delete();
        add_exp(10, 20, 1);
        chk("t1_done_cyc", done_cyc, 17);
        chk("t1_busy_cyc", busy_cyc, 16);
        check_writes("t1_wr");
        step();
        chk("t1_done_pulse", int'(done), 0);

        // 2: erase old square, draw new one
        run_redraw(100, 200, 0, 0, 0, 0);
        exp_q.delete();
        add_exp(10, 20, 0);
        add_exp(100, 200, 1);
        chk("t2_done_cyc", done_cyc, 33);
        chk("t2_busy_cyc", busy_cyc, 32);
        check_writes("t2_wr");
        step();

        // 3: bottom-right corner, clipped draw
        run_redraw(638, 478, 0, 0, 0, 0);
        exp_q.delete();
        add_exp(100, 200, 0);
        exp_q.push_back(pk(638, 478, 1));
        exp_q.push_back(pk(639, 478, 1));
        exp_q.push_back(pk(638, 479, 1));
        exp_q.push_back(pk(639, 479, 1));
        chk("t3_done_cyc", done_cyc, 33);
        chk("t3_busy_cyc", busy_cyc, 32);
        check_writes("t3_wr");
        step();

        // 4: ready stalled for 3 cycles on the 5th draw pixel (50,61)
        run_redraw(50, 60, 21, 3, 0, 0);
        exp_q.delete();
        exp_q.push_back(pk(638, 478, 0));
        exp_q.push_back(pk(639, 478, 0));
        exp_q.push_back(pk(638, 479, 0));
        exp_q.push_back(pk(639, 479, 0));
        add_exp(50, 60, 1);
        chk("t4_done_cyc", done_cyc, 36);
        chk("t4_busy_cyc", busy_cyc, 35);
        check_writes("t4_wr");
        chk("t4_snap_count", snap_q.size(), 3);
        for (int i = 0; i < snap_q.size(); i++) chk("t4_stall_hold", snap_q[i], (1 << 23) | pk(50, 61, 1));
        step();

        // 5a: start mid-draw and in DONE are both ignored
        run_redraw(200, 100, 0, 0, 20, 0);
        exp_q.delete();
        add_exp(50, 60, 0);
        add_exp(200, 100, 1);
        chk("t5_done_cyc", done_cyc, 33);
        check_writes("t5_wr");
        x_loc = 11'd400;
        y_loc = 11'd400;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t5_idle_busy", int'(busy), 0);
            chk("t5_idle_we", int'(pix.px_we), 0);
            step();
        end

        // 5b: reset on the 8th draw pixel, then the next start skips erase
        run_redraw(300, 300, 0, 0, 0, 24);
        check_idle_outputs("t5_rst");
        step();
        run_redraw(5, 5, 0, 0, 0, 0);
        exp_q.delete();
        add_exp(5, 5, 1);
        chk("t5_post_done_cyc", done_cyc, 17);
        chk("t5_post_busy_cyc", busy_cyc, 16);
        check_writes("t5_post_wr");
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
